// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the three sides of the video RAM arbiter into one interface:
//   - scanout fetcher: vid_req, vid_addr -> vid_data, vid_valid, vid_stall
//   - CPU bus:         cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_ack
//   - RAM port:        ram_addr, ram_wdata, ram_we -> ram_q
// Modports:
//   slave  : the arbiter itself
//   master : the environment (fetcher, CPU decode and RAM)
// ---------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int AW = 13
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_valid;
    logic          vid_stall;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;

    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_q;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        output vid_data, vid_valid, vid_stall, cpu_rdata, cpu_ack,
               ram_addr, ram_wdata, ram_we
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        input  vid_data, vid_valid, vid_stall, cpu_rdata, cpu_ack,
               ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous video RAM (8-bit data, 1-cycle read
// latency) between the display scanout fetcher and the CPU bus. Video has
// priority; a CPU that has waited MAX_WAIT consecutive cycles is forced in
// for one slot. One RAM slot is issued per cycle.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : vram_arbiter_if.slave (fetcher, CPU and RAM signals)
// Parameters:
//   AW       : RAM address width
//   MAX_WAIT : CPU wait cycles before forced priority
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int AW       = 13,
    parameter int MAX_WAIT = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    vram_arbiter_if.slave bus
);
    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_CPU   = 2'd2
    } owner_e;

    owner_e        owner_r;
    owner_e        grant_s;
    logic          was_read_r;
    logic          ack_block_r;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_nxt_s;
    logic          vid_stall_r;
    logic [7:0]    vid_hold_r;
    logic [7:0]    cpu_hold_r;
    logic          cpu_ok_s;
    logic          force_s;
    logic [7:0]    vid_data_s;
    logic [7:0]    cpu_rdata_s;

    // Slot decision: forced CPU beats video, video beats a normal CPU request.
    // While reset is asserted nothing is granted so the RAM is never written.
    always_comb begin
        cpu_ok_s = bus.cpu_req & ~ack_block_r;
        force_s  = cpu_ok_s & (wait_cnt_r == MAX_CNT);
        grant_s  = OWN_NONE;
        if (!reset_n) begin
            grant_s = OWN_NONE;
        end else if (force_s) begin
            grant_s = OWN_CPU;
        end else if (bus.vid_req) begin
            grant_s = OWN_VIDEO;
        end else if (cpu_ok_s) begin
            grant_s = OWN_CPU;
        end else begin
            grant_s = OWN_NONE;
        end
    end

    // RAM port drive, combinational from the current grant.
    always_comb begin
        bus.ram_addr  = {AW{1'b0}};
        bus.ram_wdata = 8'h00;
        bus.ram_we    = 1'b0;
        case (grant_s)
            OWN_VIDEO: begin
                bus.ram_addr = bus.vid_addr;
            end
            OWN_CPU: begin
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_wdata = bus.cpu_wdata;
                bus.ram_we    = bus.cpu_we;
            end
            default: begin
                bus.ram_addr  = {AW{1'b0}};
                bus.ram_wdata = 8'h00;
                bus.ram_we    = 1'b0;
            end
        endcase
    end

    // Starvation counter: counts cycles a live CPU request is passed over,
    // clears when the CPU is served or withdraws, saturates at MAX_WAIT.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (!bus.cpu_req || (grant_s == OWN_CPU)) begin
            wait_cnt_nxt_s = {CW{1'b0}};
        end else if (cpu_ok_s && (wait_cnt_r != MAX_CNT)) begin
            wait_cnt_nxt_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Return stage: RAM data is live in the cycle after issue; the hold
    // registers keep the last returned value for the rest of the time.
    always_comb begin
        vid_data_s  = vid_hold_r;
        cpu_rdata_s = cpu_hold_r;
        if (owner_r == OWN_VIDEO) begin
            vid_data_s = bus.ram_q;
        end else begin
            vid_data_s = vid_hold_r;
        end
        if ((owner_r == OWN_CPU) && was_read_r) begin
            cpu_rdata_s = bus.ram_q;
        end else begin
            cpu_rdata_s = cpu_hold_r;
        end
    end

    // Issue/state registers; reset discards any in-flight return.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_r     <= OWN_NONE;
            was_read_r  <= 1'b0;
            ack_block_r <= 1'b0;
            wait_cnt_r  <= {CW{1'b0}};
            vid_stall_r <= 1'b0;
            vid_hold_r  <= 8'h00;
            cpu_hold_r  <= 8'h00;
        end else begin
            owner_r <= grant_s;
            if (grant_s == OWN_CPU) begin
                was_read_r <= ~bus.cpu_we;
            end
            // Blocks re-issue of the still-held cpu_req during its ack cycle.
            ack_block_r <= (grant_s == OWN_CPU);
            wait_cnt_r  <= wait_cnt_nxt_s;
            vid_stall_r <= bus.vid_req & (grant_s != OWN_VIDEO);
            vid_hold_r  <= vid_data_s;
            cpu_hold_r  <= cpu_rdata_s;
        end
    end

    assign bus.vid_valid = (owner_r == OWN_VIDEO);
    assign bus.cpu_ack   = (owner_r == OWN_CPU);
    assign bus.vid_stall = vid_stall_r;
    assign bus.vid_data  = vid_data_s;
    assign bus.cpu_rdata = cpu_rdata_s;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural single-port RAM
// (registered read, 1-cycle latency). RAM is preloaded with pat(a) = a[7:0]^0xB5.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;
    logic clock;
    logic reset_n;
    logic mem_init;
    int   n_checks;
    int   n_fail;

    logic [7:0] mem [0:8191];

    vram_arbiter_if #(.AW(13)) bus ();

    vram_arbiter #(.AW(13), .MAX_WAIT(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: write-first not needed, read returns pre-write data.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= pat(13'(i));
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_q <= mem[bus.ram_addr];
    end

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ 8'hB5;
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        n_checks++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vid_valid: got %b expected 0", bus.vid_valid); end
        n_checks++; if (bus.vid_stall !== 1'b0) begin n_fail++; $display("FAIL rst_vid_stall: got %b expected 0", bus.vid_stall); end
        n_checks++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ack: got %b expected 0", bus.cpu_ack); end
        n_checks++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b expected 0", bus.ram_we); end
        n_checks++; if (bus.vid_data !== 8'h00) begin n_fail++; $display("FAIL rst_vid_data: got %h expected 00", bus.vid_data); end
        n_checks++; if (bus.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h expected 00", bus.cpu_rdata); end
        n_checks++; if (bus.ram_addr !== 13'h0000) begin n_fail++; $display("FAIL rst_ram_addr: got %h expected 0000", bus.ram_addr); end
    endtask

    task automatic test_idle_read;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0010;
        #1;
        n_checks++; if (bus.ram_addr !== 13'h0010) begin n_fail++; $display("FAIL rd_c0_addr: got %h expected 0010", bus.ram_addr); end
        n_checks++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL rd_c0_we: got %b expected 0", bus.ram_we); end
        step;
        n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rd_c1_ack: got %b expected 1", bus.cpu_ack); end
        n_checks++; if (bus.cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_c1_rdata: got %h expected a5", bus.cpu_rdata); end
        n_checks++; if (bus.ram_addr !== 13'h0000) begin n_fail++; $display("FAIL rd_c1_block: got ram_addr %h expected 0000", bus.ram_addr); end
        bus.cpu_req = 1'b0;
        step;
        n_checks++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd_c2_ack: got %b expected 0", bus.cpu_ack); end
        n_checks++; if (bus.cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_c2_hold: got %h expected a5", bus.cpu_rdata); end
    endtask

    task automatic test_write_readback;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1FFF; bus.cpu_wdata = 8'h3C;
        #1;
        n_checks++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_c0_we: got %b expected 1", bus.ram_we); end
        n_checks++; if (bus.ram_addr !== 13'h1FFF) begin n_fail++; $display("FAIL wr_c0_addr: got %h expected 1fff", bus.ram_addr); end
        step;
        n_checks++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_c1_we: got %b expected 0", bus.ram_we); end
        n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_c1_ack: got %b expected 1", bus.cpu_ack); end
        n_checks++; if (bus.cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL wr_c1_rdata_hold: got %h expected a5", bus.cpu_rdata); end
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        step;
        bus.cpu_req = 1'b1;
        step;
        n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rb_ack: got %b expected 1", bus.cpu_ack); end
        n_checks++; if (bus.cpu_rdata !== 8'h3C) begin n_fail++; $display("FAIL rb_rdata: got %h expected 3c", bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        step;
    endtask

    task automatic test_simultaneous;
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0020;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0030;
        #1;
        n_checks++; if (bus.ram_addr !== 13'h0020) begin n_fail++; $display("FAIL sim_c0_addr: got %h expected 0020", bus.ram_addr); end
        step;
        n_checks++; if (bus.vid_valid !== 1'b1) begin n_fail++; $display("FAIL sim_c1_vvalid: got %b expected 1", bus.vid_valid); end
        n_checks++; if (bus.vid_data !== 8'h95) begin n_fail++; $display("FAIL sim_c1_vdata: got %h expected 95", bus.vid_data); end
        n_checks++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL sim_c1_ack: got %b expected 0", bus.cpu_ack); end
        n_checks++; if (bus.vid_stall !== 1'b0) begin n_fail++; $display("FAIL sim_c1_stall: got %b expected 0", bus.vid_stall); end
        bus.vid_req = 1'b0;
        #1;
        n_checks++; if (bus.ram_addr !== 13'h0030) begin n_fail++; $display("FAIL sim_c1_cpu_addr: got %h expected 0030", bus.ram_addr); end
        step;
        n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL sim_c2_ack: got %b expected 1", bus.cpu_ack); end
        n_checks++; if (bus.cpu_rdata !== 8'h85) begin n_fail++; $display("FAIL sim_c2_rdata: got %h expected 85", bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        step;
    endtask

    task automatic test_starvation;
        logic [12:0] granted;
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0100; bus.cpu_wdata = 8'h77;
        #1;
        for (int t = 0; t < 12; t++) begin
            n_checks++; if (bus.ram_we !== (t == 8)) begin n_fail++; $display("FAIL stv_we c%0d: got %b expected %b", t, bus.ram_we, (t == 8)); end
            n_checks++; if (bus.ram_addr !== ((t == 8) ? 13'h0100 : bus.vid_addr)) begin n_fail++; $display("FAIL stv_addr c%0d: got %h", t, bus.ram_addr); end
            granted = bus.vid_addr;
            step;
            n_checks++; if (bus.cpu_ack !== (t == 8)) begin n_fail++; $display("FAIL stv_ack c%0d: got %b expected %b", t + 1, bus.cpu_ack, (t == 8)); end
            n_checks++; if (bus.vid_stall !== (t == 8)) begin n_fail++; $display("FAIL stv_stall c%0d: got %b expected %b", t + 1, bus.vid_stall, (t == 8)); end
            n_checks++; if (bus.vid_valid !== (t != 8)) begin n_fail++; $display("FAIL stv_vvalid c%0d: got %b expected %b", t + 1, bus.vid_valid, (t != 8)); end
            if (t != 8) begin
                n_checks++; if (bus.vid_data !== pat(granted)) begin n_fail++; $display("FAIL stv_vdata c%0d: got %h expected %h", t + 1, bus.vid_data, pat(granted)); end
                bus.vid_addr = bus.vid_addr + 13'd1;
            end else begin
                bus.cpu_req = 1'b0;
            end
            #1;
        end
        bus.vid_req = 1'b0;
        step;
    endtask

    task automatic test_abandon;
        int found;
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0040;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0200;
        #1;
        for (int t = 0; t < 6; t++) begin
            if (t == 3) begin bus.cpu_req = 1'b0; #1; end
            n_checks++; if (bus.ram_addr !== bus.vid_addr) begin n_fail++; $display("FAIL ab_addr c%0d: got %h expected %h", t, bus.ram_addr, bus.vid_addr); end
            step;
            n_checks++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL ab_ack c%0d: got %b expected 0", t + 1, bus.cpu_ack); end
            bus.vid_addr = bus.vid_addr + 13'd1;
            #1;
        end
        // A cleared counter means the re-raised request waits the full 8 slots.
        bus.cpu_req = 1'b1;
        #1;
        found = -1;
        for (int t = 0; t < 20 && found < 0; t++) begin
            if (bus.ram_addr === 13'h0200) begin
                found = t;
            end else begin
                step;
                if (bus.vid_valid) bus.vid_addr = bus.vid_addr + 13'd1;
                #1;
            end
        end
        n_checks++; if (found != 8) begin n_fail++; $display("FAIL ab_regrant_cycle: got %0d expected 8", found); end
        step;
        n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL ab_regrant_ack: got %b expected 1", bus.cpu_ack); end
        n_checks++; if (bus.cpu_rdata !== 8'hB5) begin n_fail++; $display("FAIL ab_regrant_rdata: got %h expected b5", bus.cpu_rdata); end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        step;
    endtask

    task automatic test_reset_mid;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0300; bus.cpu_wdata = 8'h11;
        #1;
        n_checks++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL rm_c0_we: got %b expected 1", bus.ram_we); end
        step;
        n_checks++; if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rm_c1_ack: got %b expected 1", bus.cpu_ack); end
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0005;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rm_ack: got %b expected 0", bus.cpu_ack); end
        n_checks++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL rm_vvalid: got %b expected 0", bus.vid_valid); end
        n_checks++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL rm_we: got %b expected 0", bus.ram_we); end
        n_checks++; if (bus.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rm_rdata: got %h expected 00", bus.cpu_rdata); end
        step;
        n_checks++; if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL rm_held_vvalid: got %b expected 0", bus.vid_valid); end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        reset_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step;
            n_checks++; if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rm_post_ack c%0d: got %b expected 0", t, bus.cpu_ack); end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset_n = 1'b0; mem_init = 1'b1;
        bus.vid_req = 1'b0; bus.vid_addr = 13'h0000;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0000; bus.cpu_wdata = 8'h00;
        step;
        step;
        test_reset;
        mem_init = 1'b0;
        reset_n = 1'b1;
        step;
        test_idle_read;
        test_write_readback;
        test_simultaneous;
        test_starvation;
        test_abandon;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (8-bit, 1-cycle read latency) between two requesters:
  - the display scanout fetcher (read-only, latency-critical);
  - the CPU bus (read/write).
- Sits between the CPU address decode for the CGA window and the 8 KB video store, so that store can be single-ported.
- Video has priority; the CPU is stalled through a req/ack handshake, with a starvation guard.

Parameters:
- AW, 13, RAM address width in bits.
- MAX_WAIT, 8, consecutive CPU wait cycles after which the CPU gets forced priority for one slot.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  scanout read request, level; held until vid_valid.
- vid_addr  in  AW  scanout read address.
- vid_data  out  8  scanout read data.
- vid_valid  out  1  vid_data valid, one cycle after video grant.
- vid_stall  out  1  pulses high in any cycle vid_req=1 and video was not granted.
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data; valid when cpu_ack=1 and the access was a read.
- cpu_ack  out  1  one-cycle pulse, one cycle after CPU grant.
- ram_addr  out  AW  RAM address, combinational from grant.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  8  RAM read data, registered inside the RAM, valid the cycle after the address.

Behaviour:
- Reset values (async assert, synchronous deassert is the caller's concern):
  - vid_valid, vid_stall, cpu_ack, ram_we = 0.
  - vid_data, cpu_rdata = 0.
  - Wait counter = 0; ack_block flag = 0; owner register = NONE.
- Grant decision, one slot per cycle, combinational from current inputs and registered state:
  - cpu_ok = cpu_req & ~ack_block.
  - force = cpu_ok & (wait_cnt == MAX_WAIT).
  - If force: grant CPU.
  - Else if vid_req: grant VIDEO.
  - Else if cpu_ok: grant CPU.
  - Else: NONE.
- RAM drive:
  - VIDEO: ram_addr=vid_addr, ram_we=0.
  - CPU: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
  - NONE: ram_addr=0, ram_we=0, ram_wdata=0.
- Issue register: owner <= grant, was_read <= ~cpu_we (CPU grant only).
- Return stage, the cycle after issue:
  - owner=VIDEO: vid_valid=1, vid_data=ram_q.
  - owner=CPU: cpu_ack=1; if was_read, cpu_rdata=ram_q, else cpu_rdata holds its previous value.
  - vid_data and cpu_rdata hold their values otherwise.
- ack_block:
  - Set in the cycle after a CPU grant and cleared the following cycle.
  - This prevents the still-held cpu_req from being re-issued while cpu_ack is high.
  - Consequence: at most one CPU access every 2 cycles; best-case CPU latency is req->ack = 1 cycle.
- Video has no equivalent block. The fetcher must treat vid_valid as consuming its request and present a new address or drop vid_req in that cycle. Back-to-back video grants every cycle are legal: one read per cycle.
- wait_cnt:
  - Increments when cpu_ok=1 and grant != CPU.
  - Resets to 0 on CPU grant, or when cpu_req=0.
  - Saturates at MAX_WAIT.
  - Worst-case CPU latency is MAX_WAIT+1 cycles to ack.
- vid_stall = vid_req & (grant != VIDEO), registered; it only happens on forced CPU slots.
- cpu_req dropping while waiting: no access is performed and wait_cnt clears.
- Reset mid-operation: any in-flight return is discarded and no ack is issued after reset.
- A write is committed to RAM in its grant cycle. The ack only signals completion.

Test Plan:
- Idle CPU read: cpu_req=1, we=0, addr=0x0010, RAM holds 0xA5, no vid_req.
  -> ram_addr=0x0010 in cycle 0; cpu_ack=1 and cpu_rdata=0xA5 in cycle 1; no second RAM access in cycle 1 (ack_block).
- CPU write then read back: write 0x3C to 0x1FFF, deassert req after ack, then read 0x1FFF.
  -> ram_we=1 exactly one cycle; the read returns 0x3C.
- Continuous video plus CPU write, MAX_WAIT=8: vid_req held high, addresses 0..n.
  -> CPU granted in cycle 8; vid_stall=1 in cycle 9 only; cpu_ack in cycle 9; video resumes in cycle 9 with vid_valid gap of exactly one cycle.
- Simultaneous request at wait_cnt=0: vid_req=1 and cpu_req=1 at the same edge.
  -> video granted first; vid_valid next cycle with correct data; CPU waits.
- CPU abandons: cpu_req high 3 cycles under video load, then low.
  -> no CPU access, no cpu_ack, wait_cnt back to 0.
- Reset mid-operation: assert reset_n=0 in the cycle after a CPU grant.
  -> cpu_ack, vid_valid, ram_we go 0 immediately; cpu_rdata=0; no ack after release.
